// File: rtl/mag_compare4.sv
// rtl/mag_compare4.sv - registered unsigned magnitude comparator with one-hot {gt, eq, lt} output
module mag_compare4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [2:0]       Y
);

  logic gt;
  logic lt;
  logic decided;

  // MSB-first cascade: the first differing bit from the top settles the relation.
  always_comb begin
    gt      = 1'b0;
    lt      = 1'b0;
    decided = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!decided && (A[i] != B[i])) begin
        decided = 1'b1;
        gt      = A[i];
        lt      = B[i];
      end
    end
  end

  // 3'b000 marks "no result yet" while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Y <= 3'b000;
    end else begin
      Y <= {gt, ~decided, lt};
    end
  end

endmodule

// File: tb/tb_mag_compare4.sv
// tb/tb_mag_compare4.sv - scoreboard bench for mag_compare4 at WIDTH = 4
module tb_mag_compare4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] A;
  logic [3:0] B;
  logic [2:0] Y;

  int errors = 0;
  int checks = 0;
  logic [2:0] exp_q[$];

  mag_compare4 #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .A    (A),
    .B    (B),
    .Y    (Y)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] model(input logic [3:0] a, input logic [3:0] b);
    if (a > b) return 3'b100;
    else if (a == b) return 3'b010;
    else return 3'b001;
  endfunction

  task automatic test_reset();
    logic [2:0] e;
    rst_n = 1'b1;
    A = 4'd5;
    B = 4'd2;
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (Y !== 3'b000) begin
      errors++;
      $display("FAIL reset_async: Y=%b expected 000", Y);
    end
    @(posedge clk); #1;
    checks++;
    if (Y !== 3'b000) begin
      errors++;
      $display("FAIL reset_hold: Y=%b expected 000", Y);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(3'b100);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    checks++;
    if (Y !== e) begin
      errors++;
      $display("FAIL reset_release: Y=%b expected %b", Y, e);
    end
  endtask

  task automatic test_directed();
    logic [3:0] ta[10] = '{4'd1, 4'd3, 4'd1, 4'd7, 4'd6, 4'd3, 4'd0, 4'd15, 4'd0, 4'd8};
    logic [3:0] tb[10] = '{4'd0, 4'd3, 4'd5, 4'd2, 4'd6, 4'd5, 4'd0, 4'd0, 4'd15, 4'd7};
    logic [2:0] te[10] = '{3'b100, 3'b010, 3'b001, 3'b100, 3'b010, 3'b001,
                           3'b010, 3'b100, 3'b001, 3'b100};
    logic [2:0] e;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      A = ta[i];
      B = tb[i];
      exp_q.push_back(te[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (Y !== e) begin
        errors++;
        $display("FAIL directed[%0d] A=%0d B=%0d: Y=%b expected %b", i, ta[i], tb[i], Y, e);
      end
    end
  endtask

  task automatic test_latency();
    logic [2:0] e;
    logic [2:0] y_hold;
    logic [3:0] a;
    logic [3:0] b;
    @(negedge clk);
    for (int i = 0; i < 24; i++) begin
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      A = a;
      B = b;
      exp_q.push_back(model(a, b));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      y_hold = Y;
      checks++;
      if (Y !== e) begin
        errors++;
        $display("FAIL latency[%0d] A=%0d B=%0d: Y=%b expected %b", i, a, b, Y, e);
      end
      // Glitch the inputs between edges; Y must not move.
      #1 A = ~a;
      B = ~b ^ 4'd1;
      #1 A = b;
      B = a;
      @(negedge clk);
      checks++;
      if (Y !== y_hold) begin
        errors++;
        $display("FAIL stable[%0d]: Y=%b expected %b", i, Y, y_hold);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [2:0] e;
    @(negedge clk);
    A = 4'd9;
    B = 4'd9;
    exp_q.push_back(3'b010);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    checks++;
    if (Y !== e) begin
      errors++;
      $display("FAIL pre_pulse: Y=%b expected %b", Y, e);
    end
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if (Y !== 3'b000) begin
      errors++;
      $display("FAIL mid_reset_async: Y=%b expected 000", Y);
    end
    A = 4'd2;
    B = 4'd11;
    #1 rst_n = 1'b1;
    exp_q.push_back(3'b001);
    #1;
    checks++;
    if (Y !== 3'b000) begin
      errors++;
      $display("FAIL mid_reset_no_stale: Y=%b expected 000", Y);
    end
    @(posedge clk); #1;
    e = exp_q.pop_front();
    checks++;
    if (Y !== e) begin
      errors++;
      $display("FAIL mid_reset_fresh: Y=%b expected %b", Y, e);
    end
  endtask

  task automatic test_exhaustive();
    logic [2:0] e;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        @(negedge clk);
        A = 4'(a);
        B = 4'(b);
        exp_q.push_back(model(4'(a), 4'(b)));
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks++;
        if (Y !== e) begin
          errors++;
          $display("FAIL exhaustive A=%0d B=%0d: Y=%b expected %b", a, b, Y, e);
        end
        checks++;
        if ($countones(Y) != 1) begin
          errors++;
          $display("FAIL onehot A=%0d B=%0d: Y=%b expected one bit set", a, b, Y);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    A = 4'd0;
    B = 4'd0;
    test_reset();
    test_directed();
    test_latency();
    test_mid_reset();
    test_exhaustive();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
